// File: rtl/square_channel.sv
// Pulse-wave APU channel: duty sequencer, length counter, volume envelope and optional sweep.
// All timing is clock-enable based on system_clock; frame_tick drives the slow units.
module square_channel #(
  parameter int PRESCALE  = 48,
  parameter int OUT_W     = 24,
  parameter bit HAS_SWEEP = 1'b1
) (
  input  logic                    system_clock,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic [7:0]              NRx0,
  input  logic [7:0]              NRx1,
  input  logic [7:0]              NRx2,
  input  logic [7:0]              NRx3,
  input  logic [7:0]              NRx4,
  input  logic                    trigger,
  input  logic                    length_load,
  input  logic                    enable,
  output logic signed [OUT_W-1:0] wave,
  output logic                    active
);
  localparam int TW = $clog2(2048 * PRESCALE) + 1;

  logic [TW-1:0]    timer_q, timer_d;
  logic [2:0]       duty_step_q, duty_step_d;
  logic [2:0]       frame_step_q, frame_step_d;
  logic [6:0]       length_q, length_d;
  logic [3:0]       volume_q, volume_d;
  logic [2:0]       env_count_q, env_count_d;
  logic [3:0]       sweep_count_q, sweep_count_d;
  logic [10:0]      shadow_q, shadow_d;
  logic             sweep_en_q, sweep_en_d;
  logic             active_q, active_d;
  logic [OUT_W-1:0] wave_q, wave_d;

  logic [10:0]      f_reg, f_cur;
  logic [2:0]       sw_period, sw_shift;
  logic             sw_negate;
  logic             len_clk, sw_clk, env_clk;
  logic [11:0]      sw_new, sw_new2, trig_new;
  logic [7:0]       duty_pat;
  logic [OUT_W-1:0] mag;
  logic             unused_bits;

  function automatic logic [TW-1:0] period_cycles(input logic [10:0] f);
    logic [11:0] units;
    units = 12'd2048 - {1'b0, f};
    return TW'(units) * TW'(PRESCALE);
  endfunction

  // 12-bit result so bit 11 flags overflow past 2047
  function automatic logic [11:0] sweep_calc(input logic [10:0] s, input logic neg,
                                             input logic [2:0] sh);
    logic [11:0] delta;
    delta = {1'b0, s} >> sh;
    return neg ? ({1'b0, s} - delta) : ({1'b0, s} + delta);
  endfunction

  assign f_reg     = {NRx4[2:0], NRx3};
  assign f_cur     = HAS_SWEEP ? shadow_q : f_reg;
  assign sw_period = NRx0[6:4];
  assign sw_negate = NRx0[3];
  assign sw_shift  = NRx0[2:0];

  // A trigger in the same cycle suppresses every frame-sequencer clock
  assign len_clk = frame_tick & ~trigger & ~frame_step_q[0];
  assign sw_clk  = frame_tick & ~trigger & (frame_step_q[1:0] == 2'b10);
  assign env_clk = frame_tick & ~trigger & (frame_step_q == 3'd7);

  assign sw_new   = sweep_calc(shadow_q, sw_negate, sw_shift);
  assign sw_new2  = sweep_calc(sw_new[10:0], sw_negate, sw_shift);
  assign trig_new = sweep_calc(f_reg, sw_negate, sw_shift);

  assign unused_bits = ^{NRx0[7], NRx4[7], NRx4[5:3], sw_new2[10:0], trig_new[10:0]};

  always_comb begin
    duty_pat = 8'b0000_0001;
    case (NRx1[7:6])
      2'b00: duty_pat = 8'b0000_0001;
      2'b01: duty_pat = 8'b1000_0001;
      2'b10: duty_pat = 8'b1000_0111;
      2'b11: duty_pat = 8'b0111_1110;
      default: duty_pat = 8'b0000_0001;
    endcase
  end

  always_comb begin
    timer_d       = timer_q;
    duty_step_d   = duty_step_q;
    frame_step_d  = frame_step_q;
    length_d      = length_q;
    volume_d      = volume_q;
    env_count_d   = env_count_q;
    sweep_count_d = sweep_count_q;
    shadow_d      = shadow_q;
    sweep_en_d    = sweep_en_q;
    active_d      = active_q;
    mag           = OUT_W'(volume_q) << (OUT_W - 5);

    if (trigger) begin
      timer_d = period_cycles(f_reg);
    end else if (timer_q <= TW'(1)) begin
      timer_d     = period_cycles(f_cur);
      duty_step_d = duty_step_q + 3'd1;
    end else begin
      timer_d = timer_q - TW'(1);
    end

    if (frame_tick) frame_step_d = frame_step_q + 3'd1;

    if (length_load) begin
      length_d = 7'd64 - {1'b0, NRx1[5:0]};
    end else if (len_clk && NRx4[6] && length_q != 7'd0) begin
      length_d = length_q - 7'd1;
      if (length_q == 7'd1) active_d = 1'b0;
    end

    if (env_clk && NRx2[2:0] != 3'd0) begin
      if (env_count_q <= 3'd1) begin
        env_count_d = NRx2[2:0];
        if (NRx2[3] && volume_q != 4'd15)     volume_d = volume_q + 4'd1;
        else if (!NRx2[3] && volume_q != 4'd0) volume_d = volume_q - 4'd1;
      end else begin
        env_count_d = env_count_q - 3'd1;
      end
    end

    if (HAS_SWEEP && sw_clk && sweep_en_q) begin
      if (sweep_count_q <= 4'd1) begin
        sweep_count_d = (sw_period == 3'd0) ? 4'd8 : {1'b0, sw_period};
        if (sw_period != 3'd0) begin
          if (sw_new[11]) begin
            active_d = 1'b0;
          end else if (sw_shift != 3'd0) begin
            shadow_d = sw_new[10:0];
            if (sw_new2[11]) active_d = 1'b0;
          end
        end
      end else begin
        sweep_count_d = sweep_count_q - 4'd1;
      end
    end

    if (trigger) begin
      active_d    = 1'b1;
      if (length_d == 7'd0) length_d = 7'd64;
      volume_d    = NRx2[7:4];
      env_count_d = NRx2[2:0];
      if (HAS_SWEEP) begin
        shadow_d      = f_reg;
        sweep_count_d = (sw_period == 3'd0) ? 4'd8 : {1'b0, sw_period};
        sweep_en_d    = (sw_period != 3'd0) || (sw_shift != 3'd0);
        if (sw_shift != 3'd0 && trig_new[11]) active_d = 1'b0;
      end
    end

    if (NRx2[7:3] == 5'd0) active_d = 1'b0;

    if (!active_q)                  wave_d = '0;
    else if (duty_pat[duty_step_q]) wave_d = mag;
    else                            wave_d = '0 - mag;

    if (!enable) begin
      timer_d       = '0;
      duty_step_d   = '0;
      frame_step_d  = '0;
      length_d      = '0;
      volume_d      = '0;
      env_count_d   = '0;
      sweep_count_d = '0;
      shadow_d      = '0;
      sweep_en_d    = 1'b0;
      active_d      = 1'b0;
      wave_d        = '0;
    end
  end

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      timer_q       <= '0;
      duty_step_q   <= '0;
      frame_step_q  <= '0;
      length_q      <= '0;
      volume_q      <= '0;
      env_count_q   <= '0;
      sweep_count_q <= '0;
      shadow_q      <= '0;
      sweep_en_q    <= 1'b0;
      active_q      <= 1'b0;
      wave_q        <= '0;
    end else begin
      timer_q       <= timer_d;
      duty_step_q   <= duty_step_d;
      frame_step_q  <= frame_step_d;
      length_q      <= length_d;
      volume_q      <= volume_d;
      env_count_q   <= env_count_d;
      sweep_count_q <= sweep_count_d;
      shadow_q      <= shadow_d;
      sweep_en_q    <= sweep_en_d;
      active_q      <= active_d;
      wave_q        <= wave_d;
    end
  end

  assign wave   = wave_q;
  assign active = active_q;
endmodule
